// File: rtl/morse_decoder_if.sv
// morse_decoder_if: serial Morse line in, decoded letter code/pulses out.
// HEX0 exists only when MORSE_DECODER_HEX_EN is defined.
interface morse_decoder_if;
  logic       morse_in;
  logic [2:0] letter_code;
  logic       letter_valid;
  logic       letter_err;
  logic       busy;
`ifdef MORSE_DECODER_HEX_EN
  logic [6:0] HEX0;
`endif
  modport slave (
    input  morse_in,
    output letter_code, letter_valid, letter_err, busy
`ifdef MORSE_DECODER_HEX_EN
    , output HEX0
`endif
  );
  modport master (
    output morse_in,
    input  letter_code, letter_valid, letter_err, busy
`ifdef MORSE_DECODER_HEX_EN
    , input HEX0
`endif
  );
endinterface

// File: rtl/morse_decoder.sv
// morse_decoder: mid-unit sampling Morse receiver for letters I-P.
// Optional MORSE_DECODER_HEX_EN adds an active-low seven-segment HEX0 display.
module morse_decoder #(
  parameter int UNIT_CYCLES = 25000000,
  parameter int CNT_W       = 25
) (
  input  logic CLOCK_50,
  input  logic KEY,
  morse_decoder_if.slave m
);
  typedef enum logic [1:0] {IDLE, MARK, SPACE, DRAIN} state_t;
  state_t state;
  logic s1, line, line_d;
  logic [CNT_W-1:0] cnt;
  logic [2:0] run, ecount, code, hit_code;
  logic [3:0] pattern;
  logic valid, err, busy, hit, flip, tick, elem_ok;
  assign flip    = line ^ line_d;
  assign tick    = !flip && cnt == CNT_W'(UNIT_CYCLES/2 - 1);
  assign elem_ok = run == 3'd1 || run == 3'd3;
  // Pattern holds elements shifted in from the LSB, upper bits stay zero.
  always_comb begin
    hit = 1'b1;
    hit_code = '0;
    case ({ecount, pattern})
      7'h20: hit_code = 3'd0;
      7'h47: hit_code = 3'd1;
      7'h35: hit_code = 3'd2;
      7'h44: hit_code = 3'd3;
      7'h23: hit_code = 3'd4;
      7'h22: hit_code = 3'd5;
      7'h37: hit_code = 3'd6;
      7'h46: hit_code = 3'd7;
      default: hit = 1'b0;
    endcase
  end
  always_ff @(posedge CLOCK_50 or negedge KEY) begin
    if (!KEY) begin
      s1 <= 1'b0;
      line <= 1'b0;
      line_d <= 1'b0;
      cnt <= '0;
      run <= '0;
      ecount <= '0;
      pattern <= '0;
      code <= '0;
      valid <= 1'b0;
      err <= 1'b0;
      busy <= 1'b0;
      state <= IDLE;
    end else begin
      s1 <= m.morse_in;
      line <= s1;
      line_d <= line;
      cnt <= (flip || cnt == CNT_W'(UNIT_CYCLES - 1)) ? '0 : cnt + 1'b1;
      run <= flip ? 3'd0 : (tick && run != 3'd7) ? run + 3'd1 : run;
      valid <= 1'b0;
      err <= 1'b0;
      case (state)
        IDLE: if (flip && line) begin
          state <= MARK;
          pattern <= '0;
          ecount <= '0;
          busy <= 1'b1;
        end
        MARK: if (flip) begin
          if (elem_ok && ecount < 3'd4) begin
            pattern <= {pattern[2:0], run == 3'd3};
            ecount <= ecount + 3'd1;
            state <= SPACE;
          end else begin
            err <= 1'b1;
            state <= DRAIN;
          end
        end
        SPACE: if (flip) begin
          state <= run == 3'd1 ? MARK : DRAIN;
          err <= run != 3'd1;
        end else if (tick && run == 3'd2) begin
          code <= hit ? hit_code : code;
          valid <= hit;
          err <= !hit;
          state <= IDLE;
          busy <= 1'b0;
        end
        DRAIN: if (tick && !line && run == 3'd2) begin
          state <= IDLE;
          busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
  assign m.letter_code  = code;
  assign m.letter_valid = valid;
  assign m.letter_err   = err;
  assign m.busy         = busy;
`ifdef MORSE_DECODER_HEX_EN
  logic [6:0] hex, seg;
  always_comb begin
    seg = 7'h7F;
    case (code)
      3'd0: seg = 7'h40;
      3'd1: seg = 7'h79;
      3'd2: seg = 7'h24;
      3'd3: seg = 7'h30;
      3'd4: seg = 7'h19;
      3'd5: seg = 7'h12;
      3'd6: seg = 7'h02;
      3'd7: seg = 7'h78;
      default: seg = 7'h7F;
    endcase
  end
  always_ff @(posedge CLOCK_50 or negedge KEY) begin
    if (!KEY) hex <= 7'h7F;
    else hex <= valid ? seg : err ? 7'h7F : hex;
  end
  assign m.HEX0 = hex;
`endif
endmodule

// File: tb/tb_morse_decoder.sv
// tb_morse_decoder: directed checks of the Morse receiver at UNIT_CYCLES=8.
module tb_morse_decoder;
  logic clk = 1'b0;
  logic key = 1'b0;
  int checks = 0, errors = 0;
  int nvalid = 0, nerr = 0, both = 0;
  int v0, e0;
  string pats[8] = '{"..", ".---", "-.-", ".-..", "--", "-.", "---", ".--."};
  morse_decoder_if bus();
  morse_decoder #(.UNIT_CYCLES(8), .CNT_W(4)) dut (.CLOCK_50(clk), .KEY(key), .m(bus));
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (bus.letter_valid) nvalid <= nvalid + 1;
    if (bus.letter_err) nerr <= nerr + 1;
    if (bus.letter_valid && bus.letter_err) both <= both + 1;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    #1;
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic hi(input int n);
    bus.morse_in = 1'b1;
    repeat (n) @(negedge clk);
  endtask
  task automatic lo(input int n);
    bus.morse_in = 1'b0;
    repeat (n) @(negedge clk);
  endtask
  task automatic send(input string s, input int gap);
    for (int i = 0; i < s.len(); i++) begin
      hi(s[i] == "-" ? 24 : 8);
      lo(i == s.len() - 1 ? gap : 8);
    end
  endtask
  task automatic mark_counts();
    v0 = nvalid;
    e0 = nerr;
  endtask
  initial begin
    bus.morse_in = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_code", 32'(bus.letter_code), 0);
    chk("rst_valid", 32'(bus.letter_valid), 0);
    chk("rst_err", 32'(bus.letter_err), 0);
    chk("rst_busy", 32'(bus.busy), 0);
`ifdef MORSE_DECODER_HEX_EN
    chk("rst_hex", 32'(bus.HEX0), 32'h7F);
`endif
    key = 1'b1;
    lo(4);
    mark_counts();
    hi(16);
    chk("midJ_busy", 32'(bus.busy), 1);
    bus.morse_in = 1'b0;
    key = 1'b0;
    repeat (3) @(negedge clk);
    chk("midrst_busy", 32'(bus.busy), 0);
    chk("midrst_code", 32'(bus.letter_code), 0);
    key = 1'b1;
    lo(40);
    chk("midrst_nvalid", 32'(nvalid - v0), 0);
    chk("midrst_nerr", 32'(nerr - e0), 0);
    mark_counts();
    send("..", 40);
    chk("after_rst_I_n", 32'(nvalid - v0), 1);
    chk("after_rst_I_code", 32'(bus.letter_code), 0);
    mark_counts();
    for (int k = 0; k < 8; k++) begin
      v0 = nvalid;
      send(pats[k], 40);
      chk({"letter_n_", pats[k]}, 32'(nvalid - v0), 1);
      chk({"letter_code_", pats[k]}, 32'(bus.letter_code), 32'(k));
      chk({"letter_idle_", pats[k]}, 32'(bus.busy), 0);
    end
    chk("letters_no_err", 32'(nerr - e0), 0);
    mark_counts();
    hi(16);
    lo(12);
    chk("two_unit_err", 32'(nerr - e0), 1);
    chk("two_unit_drain_busy", 32'(bus.busy), 1);
    lo(20);
    chk("two_unit_idle", 32'(bus.busy), 0);
    chk("two_unit_code_kept", 32'(bus.letter_code), 7);
    chk("two_unit_no_valid", 32'(nvalid - v0), 0);
    mark_counts();
    send("....", 8);
    hi(8);
    lo(6);
    chk("five_dots_err", 32'(nerr - e0), 1);
    lo(34);
    chk("five_dots_idle", 32'(bus.busy), 0);
    chk("five_dots_no_valid", 32'(nvalid - v0), 0);
    mark_counts();
    send("--", 40);
    chk("M_after_drain_n", 32'(nvalid - v0), 1);
    chk("M_after_drain_code", 32'(bus.letter_code), 4);
`ifdef MORSE_DECODER_HEX_EN
    chk("hex_M", 32'(bus.HEX0), 32'h19);
`endif
    mark_counts();
    send("----", 40);
    chk("unknown_err", 32'(nerr - e0), 1);
    chk("unknown_no_valid", 32'(nvalid - v0), 0);
    chk("unknown_code_kept", 32'(bus.letter_code), 4);
`ifdef MORSE_DECODER_HEX_EN
    chk("hex_blank_err", 32'(bus.HEX0), 32'h7F);
`endif
    mark_counts();
    hi(26);
    lo(6);
    hi(10);
    lo(10);
    hi(22);
    lo(40);
    chk("jitter_K_n", 32'(nvalid - v0), 1);
    chk("jitter_K_code", 32'(bus.letter_code), 2);
    chk("jitter_K_no_err", 32'(nerr - e0), 0);
`ifdef MORSE_DECODER_HEX_EN
    chk("hex_K", 32'(bus.HEX0), 32'h24);
`endif
    mark_counts();
    lo(60);
    chk("idle_low_nothing", 32'(nvalid - v0 + nerr - e0), 0);
    chk("valid_err_overlap", 32'(both), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
